raymarch_pixel_scheduler: RTL

- Frame-level controller wrapped around the pipelined raymarcher core.
- Upstream role: scans pixel coordinates raster-order into the core, at most one per clock.
- Downstream role: tracks the core's fixed pipeline latency, captures returned RGB, and streams (address, colour) write beats to the framebuffer writer over ready/valid.
- The core cannot stall, so the block uses credit-based issue to guarantee the output FIFO never overflows.

---
 rtl/rm_pkg.sv | 23 ++
 rtl/rm_sync_fifo.sv | 57 +++++
 rtl/raymarch_pixel_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rm_pkg.sv
// Shared constants and types for the raymarch pixel scheduler.
// Consumed by raymarch_pixel_scheduler and rm_sync_fifo.
package rm_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int CORDW         = 10;
    localparam int ADDR_W        = 19;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rm_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Push and pop in the same cycle keep the count unchanged.
module rm_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/raymarch_pixel_scheduler.sv
// Frame scheduler around the fixed-latency raymarcher core.
// Define RM_FRAME_LOOP_EN to re-render frames back to back.
module raymarch_pixel_scheduler #(
    parameter int SCREEN_WIDTH  = rm_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = rm_pkg::SCREEN_HEIGHT,
    parameter int CORDW         = rm_pkg::CORDW,
    parameter int PIPE_LATENCY  = 24,
    parameter int FIFO_DEPTH    = 32,
    parameter int ADDR_W        = rm_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [CORDW-1:0]  o_pixel_x,
    output logic [CORDW-1:0]  o_pixel_y,
    input  logic [7:0]        i_red,
    input  logic [7:0]        i_green,
    input  logic [7:0]        i_blue,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data
);

    import rm_pkg::*;

    localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CW     = $clog2(FIFO_DEPTH + PIPE_LATENCY + 2) + 1;
    localparam int PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [CORDW-1:0]  x_cnt;
    logic [CORDW-1:0]  y_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [PIPE_LATENCY:0] inflight;
    logic [CW-1:0]     inflight_cnt;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              accept;
    logic              credit;
    logic              issue;
    logic              last_x;
    logic              last_y;
    logic              clear;
    rgb_t              cap;
    rgb_t              head;

    // Bit k marks a pixel presented k cycles ago; the top tap
    // lines up with that pixel's colour at the core output.
    assign push   = inflight[PIPE_LATENCY];
    assign cap    = '{r: i_red, g: i_green, b: i_blue};
    assign accept = wr_valid && wr_ready;
    assign last_x = (x_cnt == CORDW'(SCREEN_WIDTH - 1));
    assign last_y = (y_cnt == CORDW'(SCREEN_HEIGHT - 1));

    // Pixels still inside the core pipeline.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= PIPE_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight[i]);
        end
    end

    // Every in-flight pixel already owns a FIFO slot.
    assign credit = (CW'(fifo_count) + inflight_cnt + CW'(1))
                    <= CW'(FIFO_DEPTH);
    assign issue  = (state == ISSUE) && credit;

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; drain ends on the cycle the last beat leaves.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    clear     = 1'b1;
                end
            end
            ISSUE: begin
                if (issue && last_x && last_y) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_cnt == '0 &&
                    (fifo_empty ||
                     (fifo_count == FCW'(1) && accept))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
`ifdef RM_FRAME_LOOP_EN
                state_nxt = ISSUE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster scan counters and registered coordinate outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            o_pixel_x <= '0;
            o_pixel_y <= '0;
        end else if (clear) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (issue) begin
            o_pixel_x <= x_cnt;
            o_pixel_y <= y_cnt;
            if (last_x) begin
                x_cnt <= '0;
                y_cnt <= last_y ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // In-flight delay line tracking the core latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= {inflight[PIPE_LATENCY-1:0], issue};
        end
    end

    // Framebuffer address of the beat at the FIFO head.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_cnt <= '0;
        end else if (accept) begin
            if (wr_cnt == ADDR_W'(PIXELS - 1)) begin
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    rm_sync_fifo #(
        .WIDTH ($bits(rgb_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (cap),
        .pop   (accept),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_valid = !fifo_empty;
    assign wr_addr  = wr_cnt;
    assign wr_data  = fifo_empty ? 24'd0 : head;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && fifo_full)
    );

endmodule
